// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one multi-cycle main memory between I-cache and D-cache miss handlers
//
// Serializes D-cache write-through words and 8-word block fills for both caches.
// Block reads are issued back to back, one per cycle. Returning words are steered
// to the owning cache together with their index inside the block.
// Return counting relies only on mem_data_valid. The nominal memory read latency
// is 4 cycles, but nothing in this block depends on it.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   icache_req/addr   I-cache fill request (level, held until icache_done), miss byte address
//   dcache_req/addr   D-cache fill request (level, held until dcache_done), miss/write byte address
//   dcache_wr_req     D-cache single-word write request, held until dcache_wr_ack
//   dcache_wdata      write data
//   mem_en/wr/addr/wdata            memory command (wr: 1 = write, 0 = read)
//   mem_data_out, mem_data_valid    memory read return
//   fill_data, fill_word_idx        returned word and its index in the block
//   icache_fill_we, dcache_fill_we  data-array write strobes for the fill owner
//   icache_done, dcache_done        pulse with the last fill word
//   dcache_wr_ack                   pulse in the cycle the write is issued
//   busy                            arbiter not idle

module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_req,
  input  logic [15:0] icache_addr,
  input  logic        dcache_req,
  input  logic [15:0] dcache_addr,
  input  logic        dcache_wr_req,
  input  logic [15:0] dcache_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word_idx,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic        icache_done,
  output logic        dcache_done,
  output logic        dcache_wr_ack,
  output logic        busy
);

  localparam logic [3:0] BLOCK_WORDS = 4'd8;
  localparam logic [2:0] LAST_WORD   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner_d, owner_d_nxt;          // 1 = D-cache owns the fill
  logic        last_fill_d, last_fill_d_nxt;  // 1 = D-cache was granted the last fill
  logic [15:0] base, base_nxt;
  logic [3:0]  issue_cnt, issue_cnt_nxt;
  logic [2:0]  recv_cnt, recv_cnt_nxt;
  logic [15:0] wr_addr, wr_addr_nxt;
  logic [15:0] wr_data, wr_data_nxt;
  logic        grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_d     <= 1'b0;
      last_fill_d <= 1'b0;   // I counted as last, so D wins the first contended fill
      base        <= 16'h0000;
      issue_cnt   <= 4'd0;
      recv_cnt    <= 3'd0;
      wr_addr     <= 16'h0000;
      wr_data     <= 16'h0000;
    end else begin
      state       <= state_nxt;
      owner_d     <= owner_d_nxt;
      last_fill_d <= last_fill_d_nxt;
      base        <= base_nxt;
      issue_cnt   <= issue_cnt_nxt;
      recv_cnt    <= recv_cnt_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_data     <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_d_nxt     = owner_d;
    last_fill_d_nxt = last_fill_d;
    base_nxt        = base;
    issue_cnt_nxt   = issue_cnt;
    recv_cnt_nxt    = recv_cnt;
    wr_addr_nxt     = wr_addr;
    wr_data_nxt     = wr_data;
    grant_d         = 1'b0;

    mem_en          = 1'b0;
    mem_wr          = 1'b0;
    mem_addr        = 16'h0000;
    mem_wdata       = 16'h0000;
    fill_data       = mem_data_out;
    fill_word_idx   = 3'd0;
    icache_fill_we  = 1'b0;
    dcache_fill_we  = 1'b0;
    icache_done     = 1'b0;
    dcache_done     = 1'b0;
    dcache_wr_ack   = 1'b0;
    busy            = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        // A pending write always goes ahead of any fill.
        if (dcache_wr_req) begin
          state_nxt   = ST_WRITE;
          wr_addr_nxt = dcache_addr;
          wr_data_nxt = dcache_wdata;
        end else if (icache_req || dcache_req) begin
          // Contended fills alternate; otherwise the lone requester wins.
          grant_d         = (icache_req && dcache_req) ? ~last_fill_d : dcache_req;
          state_nxt       = ST_FILL;
          owner_d_nxt     = grant_d;
          last_fill_d_nxt = grant_d;
          base_nxt        = (grant_d ? dcache_addr : icache_addr) & 16'hFFF0;
          issue_cnt_nxt   = 4'd0;
          recv_cnt_nxt    = 3'd0;
        end
      end

      ST_WRITE: begin
        mem_en        = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = wr_addr;
        mem_wdata     = wr_data;
        dcache_wr_ack = 1'b1;
        state_nxt     = ST_IDLE;
      end

      ST_FILL: begin
        if (issue_cnt < BLOCK_WORDS) begin
          mem_en        = 1'b1;
          // base is block-aligned, so this never carries out of the block.
          mem_addr      = base + {12'h000, issue_cnt[2:0], 1'b0};
          issue_cnt_nxt = issue_cnt + 4'd1;
        end
        if (mem_data_valid) begin
          fill_word_idx  = recv_cnt;
          icache_fill_we = ~owner_d;
          dcache_fill_we = owner_d;
          recv_cnt_nxt   = recv_cnt + 3'd1;
          if (recv_cnt == LAST_WORD) begin
            icache_done = ~owner_d;
            dcache_done = owner_d;
            state_nxt   = ST_IDLE;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // While reset is held, the in-flight operation is dead: no strobes,
    // no done/ack, and stale memory returns are dropped.
    if (rst) begin
      mem_en         = 1'b0;
      mem_wr         = 1'b0;
      mem_addr       = 16'h0000;
      mem_wdata      = 16'h0000;
      fill_word_idx  = 3'd0;
      icache_fill_we = 1'b0;
      dcache_fill_we = 1'b0;
      icache_done    = 1'b0;
      dcache_done    = 1'b0;
      dcache_wr_ack  = 1'b0;
      busy           = 1'b0;
    end
  end

endmodule
